// File: rtl/fetch_pc_ctrl_if.sv
// Bundle of the branch-resolution, instruction-memory and decode-side signals
// of the fetch PC controller; master is the controller, slave the environment.
interface fetch_pc_ctrl_if #(
  parameter int unsigned WordSize = 32
);
  logic                br_valid;
  logic                br_taken;
  logic [WordSize-1:0] br_addr;
  logic                stall;
  logic                imem_req;
  logic [WordSize-1:0] imem_addr;
  logic                imem_ack;
  logic [WordSize-1:0] imem_data;
  logic                if_valid;
  logic [WordSize-1:0] if_pc;
  logic [WordSize-1:0] if_inst;
  logic                flush;
  logic                misalign_err;

  modport master (
    input  br_valid, br_taken, br_addr, stall, imem_ack, imem_data,
    output imem_req, imem_addr, if_valid, if_pc, if_inst, flush, misalign_err
  );

  modport slave (
    output br_valid, br_taken, br_addr, stall, imem_ack, imem_data,
    input  imem_req, imem_addr, if_valid, if_pc, if_inst, flush, misalign_err
  );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC controller: sequential instruction fetch with a 1-entry skid buffer,
// taken-branch redirect with drain of an in-flight request, misalignment fault.
module fetch_pc_ctrl #(
  parameter int unsigned         WordSize = 32,
  parameter logic [WordSize-1:0] ResetVec = '0
) (
  input  logic            clk,
  input  logic            rstn,
  fetch_pc_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DRAIN,
    S_FAULT
  } state_e;

  state_e              state_q, state_d;
  logic [WordSize-1:0] pc_q, pc_d;
  logic                req_q, req_d;
  logic [WordSize-1:0] addr_q, addr_d;
  logic                if_valid_q, if_valid_d;
  logic [WordSize-1:0] if_pc_q, if_pc_d;
  logic [WordSize-1:0] if_inst_q, if_inst_d;
  logic                skid_valid_q, skid_valid_d;
  logic [WordSize-1:0] skid_pc_q, skid_pc_d;
  logic [WordSize-1:0] skid_inst_q, skid_inst_d;
  logic                flush_q, flush_d;
  logic                misalign_q, misalign_d;

  logic redirect;
  logic ack;
  logic consumed;
  logic tgt_misaligned;

  assign redirect       = bus.br_valid & bus.br_taken & (state_q != S_FAULT);
  assign ack            = req_q & bus.imem_ack;
  assign consumed       = ~if_valid_q | ~bus.stall;
  assign tgt_misaligned = (bus.br_addr[1:0] != 2'b00);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_d        = req_q;
    addr_d       = addr_q;
    if_valid_d   = if_valid_q;
    if_pc_d      = if_pc_q;
    if_inst_d    = if_inst_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_inst_d  = skid_inst_q;
    flush_d      = 1'b0;
    misalign_d   = misalign_q;

    if (redirect) begin
      // Any ack this cycle belongs to the old path and is dropped.
      pc_d         = bus.br_addr;
      if_valid_d   = 1'b0;
      skid_valid_d = 1'b0;
      flush_d      = 1'b1;
      if (tgt_misaligned) misalign_d = 1'b1;
      if (req_q && !bus.imem_ack) begin
        state_d = S_DRAIN;
      end else if (tgt_misaligned) begin
        state_d = S_FAULT;
        req_d   = 1'b0;
      end else begin
        state_d = S_REQ;
        req_d   = 1'b1;
        addr_d  = bus.br_addr;
      end
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_REQ;

        S_REQ: begin
          if (consumed) begin
            if (skid_valid_q) begin
              if_valid_d   = 1'b1;
              if_pc_d      = skid_pc_q;
              if_inst_d    = skid_inst_q;
              skid_valid_d = 1'b0;
              if (ack) begin
                skid_valid_d = 1'b1;
                skid_pc_d    = pc_q;
                skid_inst_d  = bus.imem_data;
              end
            end else if (ack) begin
              if_valid_d = 1'b1;
              if_pc_d    = pc_q;
              if_inst_d  = bus.imem_data;
            end else begin
              if_valid_d = 1'b0;
            end
          end else if (ack) begin
            skid_valid_d = 1'b1;
            skid_pc_d    = pc_q;
            skid_inst_d  = bus.imem_data;
          end

          if (ack) pc_d = pc_q + WordSize'(4);

          // Back-to-back launch keeps a zero-wait memory at one word per cycle.
          if (req_q && !bus.imem_ack) begin
            req_d = 1'b1;
          end else if (!skid_valid_d) begin
            req_d  = 1'b1;
            addr_d = pc_d;
          end else begin
            req_d = 1'b0;
          end
        end

        S_DRAIN: begin
          if (ack) begin
            if (pc_q[1:0] != 2'b00) begin
              state_d = S_FAULT;
              req_d   = 1'b0;
            end else begin
              state_d = S_REQ;
              req_d   = 1'b1;
              addr_d  = pc_q;
            end
          end
        end

        S_FAULT: begin
          req_d        = 1'b0;
          if_valid_d   = 1'b0;
          skid_valid_d = 1'b0;
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      pc_q         <= ResetVec;
      req_q        <= 1'b0;
      addr_q       <= ResetVec;
      if_valid_q   <= 1'b0;
      if_pc_q      <= '0;
      if_inst_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_inst_q  <= '0;
      flush_q      <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      if_valid_q   <= if_valid_d;
      if_pc_q      <= if_pc_d;
      if_inst_q    <= if_inst_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_inst_q  <= skid_inst_d;
      flush_q      <= flush_d;
      misalign_q   <= misalign_d;
    end
  end

  assign bus.imem_req     = req_q;
  assign bus.imem_addr    = addr_q;
  assign bus.if_valid     = if_valid_q;
  assign bus.if_pc        = if_pc_q;
  assign bus.if_inst      = if_inst_q;
  assign bus.flush        = flush_q;
  assign bus.misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Scoreboard bench for fetch_pc_ctrl: a budgeted memory model answers fetches with
// ~addr, expected fetch addresses and decoded words are queued ahead of the run.
module tb_fetch_pc_ctrl;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_exp_t;

  logic clk;
  logic rstn;

  fetch_pc_ctrl_if #(.WordSize(32)) bus ();

  fetch_pc_ctrl #(
    .WordSize(32),
    .ResetVec(32'h0000_0100)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int          checks     = 0;
  int          failures   = 0;
  int          ack_budget = 0;
  int          mem_delay  = 0;
  int          ack_total  = 0;
  logic [31:0] addr_q[$];
  if_exp_t     if_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_fetch(input logic [31:0] a);
    if_exp_t e;
    e.pc   = a;
    e.inst = ~a;
    addr_q.push_back(a);
    if_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int max_cycles);
    int n = 0;
    while ((addr_q.size() != 0 || if_q.size() != 0) && n < max_cycles) begin
      tick();
      n++;
    end
    checks++;
    if (addr_q.size() != 0 || if_q.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout: pending addr=%0d if=%0d required 0", name,
               addr_q.size(), if_q.size());
      addr_q.delete();
      if_q.delete();
    end
  endtask

  // Memory model: acks after mem_delay held cycles, only while budget remains.
  initial begin
    int   cnt;
    logic req_seen;
    cnt          = 0;
    bus.imem_ack  = 1'b0;
    bus.imem_data = '0;
    forever begin
      @(negedge clk);
      if (bus.imem_req && ack_budget > 0 && cnt >= mem_delay) begin
        bus.imem_ack  = 1'b1;
        bus.imem_data = ~bus.imem_addr;
      end else begin
        bus.imem_ack  = 1'b0;
        bus.imem_data = 32'hDEAD_BEEF;
      end
      req_seen = bus.imem_req;
      @(posedge clk);
      if (bus.imem_ack) begin
        ack_budget--;
        cnt = 0;
      end else if (!req_seen) begin
        cnt = 0;
      end else if (ack_budget > 0) begin
        cnt++;
      end
    end
  end

  // Monitor: pops expected fetch addresses on acks and expected words on consumption.
  initial begin
    logic        prev_pend;
    logic [31:0] prev_addr;
    if_exp_t     e;
    prev_pend = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rstn) begin
        prev_pend = 1'b0;
      end else begin
        if (prev_pend) begin
          check("req_held", {31'b0, bus.imem_req}, 32'd1);
          check("addr_stable", bus.imem_addr, prev_addr);
        end
        prev_pend = bus.imem_req && !bus.imem_ack;
        prev_addr = bus.imem_addr;
        if (bus.imem_req && bus.imem_ack) begin
          ack_total++;
          if (addr_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ack: addr %h with empty queue", bus.imem_addr);
          end else begin
            check("imem_addr", bus.imem_addr, addr_q.pop_front());
          end
        end
        if (bus.if_valid && !bus.stall) begin
          if (if_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_if: pc %h inst %h with empty queue", bus.if_pc, bus.if_inst);
          end else begin
            e = if_q.pop_front();
            check("if_pc", bus.if_pc, e.pc);
            check("if_inst", bus.if_inst, e.inst);
          end
        end
        if (bus.flush) check("flush_vs_valid", {31'b0, bus.if_valid}, 32'd0);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_imem_req"}, {31'b0, bus.imem_req}, 32'd0);
    check({tag, "_imem_addr"}, bus.imem_addr, 32'h0000_0100);
    check({tag, "_if_valid"}, {31'b0, bus.if_valid}, 32'd0);
    check({tag, "_if_pc"}, bus.if_pc, 32'd0);
    check({tag, "_if_inst"}, bus.if_inst, 32'd0);
    check({tag, "_flush"}, {31'b0, bus.flush}, 32'd0);
    check({tag, "_misalign"}, {31'b0, bus.misalign_err}, 32'd0);
  endtask

  initial begin
    int nvalid, first, last, snap, nreq;
    rstn         = 1'b0;
    bus.br_valid = 1'b0;
    bus.br_taken = 1'b0;
    bus.br_addr  = '0;
    bus.stall    = 1'b0;
    repeat (3) tick();
    check_reset_outputs("rst");

    // Zero-wait streaming from the reset vector.
    mem_delay  = 0;
    ack_budget = 3;
    push_fetch(32'h100);
    push_fetch(32'h104);
    push_fetch(32'h108);
    rstn   = 1'b1;
    nvalid = 0;
    first  = -1;
    last   = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.if_valid) begin
        nvalid++;
        if (first < 0) first = i;
        last = i;
      end
    end
    check("stream_valid_cycles", nvalid, 3);
    check("stream_valid_span", last - first + 1, 3);
    wait_drain("stream", 5);
    check("stream_next_req", {31'b0, bus.imem_req}, 32'd1);
    check("stream_next_addr", bus.imem_addr, 32'h10C);

    // Delayed ack: request holds, no valid output during the wait.
    mem_delay  = 3;
    ack_budget = 1;
    push_fetch(32'h10C);
    repeat (3) tick();
    check("delay_req", {31'b0, bus.imem_req}, 32'd1);
    check("delay_addr", bus.imem_addr, 32'h10C);
    check("delay_gap_valid", {31'b0, bus.if_valid}, 32'd0);
    wait_drain("delay", 20);

    // Stall during streaming: skid takes one word, then requests pause.
    mem_delay = 0;
    for (int i = 0; i < 6; i++) push_fetch(32'h110 + 32'(i) * 32'd4);
    ack_budget = 6;
    tick();
    tick();
    bus.stall = 1'b1;
    snap      = ack_total;
    repeat (4) tick();
    check("stall_if_pc", bus.if_pc, 32'h114);
    check("stall_if_inst", bus.if_inst, ~32'h114);
    check("stall_if_valid", {31'b0, bus.if_valid}, 32'd1);
    check("stall_acks", ack_total - snap, 1);
    check("stall_no_req", {31'b0, bus.imem_req}, 32'd0);
    bus.stall = 1'b0;
    wait_drain("stall", 40);

    // Redirect while a request is waiting: drain it, then fetch the target.
    ack_budget   = 0;
    bus.br_valid = 1'b1;
    bus.br_taken = 1'b1;
    bus.br_addr  = 32'h400;
    tick();
    bus.br_valid = 1'b0;
    check("drain_flush", {31'b0, bus.flush}, 32'd1);
    check("drain_if_valid", {31'b0, bus.if_valid}, 32'd0);
    check("drain_hold_addr", bus.imem_addr, 32'h128);
    tick();
    check("drain_flush_end", {31'b0, bus.flush}, 32'd0);
    check("drain_hold_req", {31'b0, bus.imem_req}, 32'd1);
    addr_q.push_back(32'h128);
    push_fetch(32'h400);
    push_fetch(32'h404);
    mem_delay  = 2;
    ack_budget = 3;
    wait_drain("drain", 40);
    check("drain_next_addr", bus.imem_addr, 32'h408);

    // Redirect coinciding with an ack: that word is dropped.
    mem_delay = 0;
    addr_q.push_back(32'h408);
    ack_budget   = 1;
    bus.br_valid = 1'b1;
    bus.br_taken = 1'b1;
    bus.br_addr  = 32'h500;
    tick();
    bus.br_valid = 1'b0;
    check("same_flush", {31'b0, bus.flush}, 32'd1);
    check("same_req_addr", bus.imem_addr, 32'h500);
    push_fetch(32'h500);
    push_fetch(32'h504);
    ack_budget = 2;
    wait_drain("same", 20);

    // Not-taken resolution has no effect.
    push_fetch(32'h508);
    push_fetch(32'h50C);
    ack_budget   = 2;
    bus.br_valid = 1'b1;
    bus.br_taken = 1'b0;
    bus.br_addr  = 32'h700;
    tick();
    bus.br_valid = 1'b0;
    tick();
    check("nt_flush", {31'b0, bus.flush}, 32'd0);
    wait_drain("nt", 20);
    check("nt_next_addr", bus.imem_addr, 32'h510);

    // Misaligned redirect: drain, then fault with no further fetches.
    ack_budget   = 0;
    bus.br_valid = 1'b1;
    bus.br_taken = 1'b1;
    bus.br_addr  = 32'h402;
    tick();
    bus.br_valid = 1'b0;
    check("mis_err", {31'b0, bus.misalign_err}, 32'd1);
    check("mis_flush", {31'b0, bus.flush}, 32'd1);
    addr_q.push_back(32'h510);
    ack_budget = 1;
    nreq       = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.imem_req) nreq++;
    end
    check("fault_req_cycles", nreq, 0);
    check("fault_err_sticky", {31'b0, bus.misalign_err}, 32'd1);
    check("fault_if_valid", {31'b0, bus.if_valid}, 32'd0);
    wait_drain("fault", 2);

    // Reset pulse clears the fault and fetching resumes at the reset vector.
    rstn = 1'b0;
    #1;
    check_reset_outputs("rst2");
    ack_budget = 2;
    push_fetch(32'h100);
    push_fetch(32'h104);
    tick();
    rstn = 1'b1;
    wait_drain("recover", 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
